// File: rtl/avalon_crc_master.sv
// Avalon-MM initiator driving the CRC accelerator: clear, stream words, fence, settle, read CRC.
// Define CRC_TAIL_BYTE_EN to honour tail_valid/tail_byte (one trailing byte via crc_control).
module avalon_crc_master #(
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              tail_valid,
  input  logic [7:0]        tail_byte,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [31:0]       crc_result,
  output logic [CNT_W-1:0]  word_count,
  output logic              avm_chipselect,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic [31:0]       avm_readdata,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest
);

  localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [3:0] {
    StIdle,
    StClear,
    StStream,
    StFence,
`ifdef CRC_TAIL_BYTE_EN
    StTail,
    StFence2,
`endif
    StDrain,
    StRead,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       hold_q;
  logic              hold_v_q;
  logic              last_seen_q;
  logic [DrainW-1:0] drain_q;
  logic              accept;
  logic              wr_done;
  logic              rd_done;

`ifdef CRC_TAIL_BYTE_EN
  logic              tail_v_q;
  logic [7:0]        tail_b_q;
`else
  logic              unused_tail;
  assign unused_tail = ^{tail_valid, tail_byte};
`endif

  assign accept  = in_valid & in_ready;
  assign wr_done = avm_write & ~avm_waitrequest;
  assign rd_done = avm_read & ~avm_waitrequest;

  always_ff @(posedge clock) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    avm_address   = '0;
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_writedata = 32'h0;
    in_ready      = 1'b0;
    unique case (state_q)
      StIdle: if (start) state_d = StClear;
      StClear: begin
        avm_write     = 1'b1;
        avm_address   = ADDR_W'(1);
        avm_writedata = 32'h1;
        if (!avm_waitrequest) state_d = StStream;
      end
      StStream: begin
        avm_write     = hold_v_q;
        avm_writedata = hold_q;
        // A completing write frees the holding register for a same-cycle refill.
        in_ready      = ~last_seen_q & (~hold_v_q | ~avm_waitrequest);
        if (wr_done && last_seen_q) state_d = StFence;
      end
      StFence: begin
        avm_write   = 1'b1;
        avm_address = ADDR_W'(2);
        if (!avm_waitrequest) begin
`ifdef CRC_TAIL_BYTE_EN
          state_d = tail_v_q ? StTail : StDrain;
`else
          state_d = StDrain;
`endif
        end
      end
`ifdef CRC_TAIL_BYTE_EN
      StTail: begin
        avm_write     = 1'b1;
        avm_address   = ADDR_W'(2);
        avm_writedata = {1'b1, 23'h0, tail_b_q};
        if (!avm_waitrequest) state_d = StFence2;
      end
      StFence2: begin
        avm_write   = 1'b1;
        avm_address = ADDR_W'(2);
        if (!avm_waitrequest) state_d = StDrain;
      end
`endif
      StDrain: if (drain_q == DrainW'(DRAIN_CYCLES - 1)) state_d = StRead;
      StRead: begin
        avm_read    = 1'b1;
        avm_address = ADDR_W'(1);
        if (!avm_waitrequest) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    avm_chipselect = avm_read | avm_write;
  end

  assign busy = (state_q != StIdle) && (state_q != StDone);
  assign done = (state_q == StDone);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      hold_q      <= 32'h0;
      hold_v_q    <= 1'b0;
      last_seen_q <= 1'b0;
      drain_q     <= '0;
      word_count  <= '0;
      crc_result  <= 32'h0;
`ifdef CRC_TAIL_BYTE_EN
      tail_v_q    <= 1'b0;
      tail_b_q    <= 8'h0;
`endif
    end else begin
      if (state_q == StIdle && start) begin
        hold_v_q    <= 1'b0;
        last_seen_q <= 1'b0;
        word_count  <= '0;
`ifdef CRC_TAIL_BYTE_EN
        tail_v_q    <= tail_valid;
        tail_b_q    <= tail_byte;
`endif
      end
      if (accept) begin
        hold_q   <= in_data;
        hold_v_q <= 1'b1;
        if (in_last) last_seen_q <= 1'b1;
      end else if (wr_done && state_q == StStream) begin
        hold_v_q <= 1'b0;
      end
      if (wr_done && state_q == StStream) word_count <= word_count + 1'b1;
      drain_q <= (state_q == StDrain) ? drain_q + 1'b1 : '0;
      if (rd_done) crc_result <= avm_readdata;
    end
  end

endmodule
